ctrl_pipe: RTL

Pipelined control unit for the 5-stage MIPS datapath. It decodes the ID-stage opcode into the control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB control registers. It also detects load-use hazards and inserts bubbles, squashes instructions on taken branches and jumps, and keeps saturating stall and flush counters. It extends the single-cycle decoder with optional immediate-ALU opcodes, a parametrised ALU_Op width and register-address width, and a gating `NoOp` input.

---
 rtl/ctrl_pipe.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined control unit for a 5-stage MIPS datapath.
// Decodes the ID opcode into the control bundle and carries it through the
// ID/EX, EX/MEM and MEM/WB control registers. Also detects load-use hazards,
// squashes on taken branches and jumps, and counts stall and flush cycles.
// ALU_OP_W must be at least 3; ALU encodings are zero-extended to that width.
module ctrl_pipe #(
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 3,
  parameter int ENABLE_IMM = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            opCode,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  NoOp,
  input  logic                  br_taken,
  output logic                  stall,
  output logic                  ifid_flush,
  output logic                  id_jump,
  output logic                  ex_Reg_Dst,
  output logic                  ex_ALU_Src,
  output logic                  ex_Branch,
  output logic                  ex_BranchN,
  output logic [ALU_OP_W-1:0]   ex_ALU_Op,
  output logic                  mem_Mem_Read,
  output logic                  mem_Mem_Write,
  output logic                  wb_Reg_Write,
  output logic                  wb_Mem_To_Reg,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  // Decoded ID-stage bundle
  logic       d_reg_dst, d_alu_src, d_branch, d_branchn;
  logic       d_mem_read, d_mem_write, d_reg_write, d_mem_to_reg, d_jump;
  logic [2:0] d_alu_op3;

  // EX-stage copies that are not themselves outputs
  logic                  ex_mem_read_q, ex_mem_write_q, ex_reg_write_q, ex_mem_to_reg_q;
  logic [REG_ADDR_W-1:0] ex_rt_q;
  // EX/MEM copies feeding write-back
  logic                  mem_reg_write_q, mem_mem_to_reg_q;

  logic bubble;

  // Opcode decode; NoOp zeroes the whole bundle including Jump
  always_comb begin
    d_reg_dst    = 1'b0;
    d_alu_src    = 1'b0;
    d_branch     = 1'b0;
    d_branchn    = 1'b0;
    d_mem_read   = 1'b0;
    d_mem_write  = 1'b0;
    d_reg_write  = 1'b0;
    d_mem_to_reg = 1'b0;
    d_jump       = 1'b0;
    d_alu_op3    = 3'b000;
    case (opCode)
      OP_RTYPE: begin
        d_reg_dst   = 1'b1;
        d_reg_write = 1'b1;
        d_alu_op3   = 3'b010;
      end
      OP_LW: begin
        d_alu_src    = 1'b1;
        d_mem_read   = 1'b1;
        d_mem_to_reg = 1'b1;
        d_reg_write  = 1'b1;
      end
      OP_SW: begin
        d_alu_src   = 1'b1;
        d_mem_write = 1'b1;
      end
      OP_BEQ: begin
        d_branch  = 1'b1;
        d_alu_op3 = 3'b001;
      end
      OP_BNE: begin
        d_branchn = 1'b1;
        d_alu_op3 = 3'b001;
      end
      OP_J: d_jump = 1'b1;
      OP_ADDI: if (ENABLE_IMM != 0) begin
        d_alu_src   = 1'b1;
        d_reg_write = 1'b1;
      end
      OP_ANDI: if (ENABLE_IMM != 0) begin
        d_alu_src   = 1'b1;
        d_reg_write = 1'b1;
        d_alu_op3   = 3'b011;
      end
      OP_ORI: if (ENABLE_IMM != 0) begin
        d_alu_src   = 1'b1;
        d_reg_write = 1'b1;
        d_alu_op3   = 3'b100;
      end
      default: ;
    endcase
    if (NoOp) begin
      d_reg_dst    = 1'b0;
      d_alu_src    = 1'b0;
      d_branch     = 1'b0;
      d_branchn    = 1'b0;
      d_mem_read   = 1'b0;
      d_mem_write  = 1'b0;
      d_reg_write  = 1'b0;
      d_mem_to_reg = 1'b0;
      d_jump       = 1'b0;
      d_alu_op3    = 3'b000;
    end
  end

  // Hazard and squash signals; a taken branch squashes the stalled instruction anyway
  assign stall      = ex_mem_read_q && ((ex_rt_q == id_rs) || (ex_rt_q == id_rt)) && !br_taken;
  assign id_jump    = d_jump && !br_taken;
  assign ifid_flush = br_taken || id_jump;
  assign bubble     = br_taken || stall;

  // ID/EX register: bubble on taken branch or load-use stall, else decoded bundle
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      ex_Reg_Dst       <= 1'b0;
      ex_ALU_Src       <= 1'b0;
      ex_Branch        <= 1'b0;
      ex_BranchN       <= 1'b0;
      ex_ALU_Op        <= '0;
      ex_mem_read_q    <= 1'b0;
      ex_mem_write_q   <= 1'b0;
      ex_reg_write_q   <= 1'b0;
      ex_mem_to_reg_q  <= 1'b0;
      ex_rt_q          <= '0;
    end else begin
      ex_Reg_Dst       <= d_reg_dst;
      ex_ALU_Src       <= d_alu_src;
      ex_Branch        <= d_branch;
      ex_BranchN       <= d_branchn;
      ex_ALU_Op        <= ALU_OP_W'(d_alu_op3);
      ex_mem_read_q    <= d_mem_read;
      ex_mem_write_q   <= d_mem_write;
      ex_reg_write_q   <= d_reg_write;
      ex_mem_to_reg_q  <= d_mem_to_reg;
      ex_rt_q          <= id_rt;
    end
  end

  // EX/MEM and MEM/WB always advance; stalls never freeze them
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_Mem_Read     <= 1'b0;
      mem_Mem_Write    <= 1'b0;
      mem_reg_write_q  <= 1'b0;
      mem_mem_to_reg_q <= 1'b0;
      wb_Reg_Write     <= 1'b0;
      wb_Mem_To_Reg    <= 1'b0;
    end else begin
      mem_Mem_Read     <= ex_mem_read_q;
      mem_Mem_Write    <= ex_mem_write_q;
      mem_reg_write_q  <= ex_reg_write_q;
      mem_mem_to_reg_q <= ex_mem_to_reg_q;
      wb_Reg_Write     <= mem_reg_write_q;
      wb_Mem_To_Reg    <= mem_mem_to_reg_q;
    end
  end

  // Saturating stall and flush event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (ifid_flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
